// File: rtl/tri_state_bus_tx_ctrl.sv
// tri_state_bus_tx_ctrl
// Serial frame sequencer feeding the data/enable pair of a tri-state line
// buffer. One word per valid/ready handshake is sent as:
//   start(0), data MSB-first, [parity], stop(1),
// and then the line is released (drv_en=0) for a turnaround window.
// Optional feature: define TRI_BUS_PARITY_EN to insert an even-parity bit
// after the data bits.
// All outputs are registered. Each one is computed from the next-state
// values, so the outputs line up with the state they describe.
module tri_state_bus_tx_ctrl #(
  parameter int DATA_W    = 8,
  parameter int BIT_DIV   = 4,
  parameter int TURN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              drv_in,
  output logic              drv_en,
  output logic              busy
);

  localparam int TW     = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IDX_MAX = (DATA_W > TURN_BITS) ? DATA_W : TURN_BITS;
  localparam int IW     = $clog2(IDX_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef TRI_BUS_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_TURN   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  // Bit index while in DATA; it is reused as the turnaround period counter.
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic              drv_in_q, drv_in_d;
  logic              drv_en_q, drv_en_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              timer_wrap;
`ifdef TRI_BUS_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign timer_wrap = (timer_q == TW'(BIT_DIV - 1));

  // Next-state logic: FSM transitions, bit timer, bit index, and shift register.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    sreg_d   = sreg_q;
`ifdef TRI_BUS_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q == S_IDLE) begin
      timer_d = '0;
    end else if (timer_wrap) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          sreg_d   = tx_data;
          idx_d    = IW'(DATA_W - 1);
          state_d  = S_START;
`ifdef TRI_BUS_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (timer_wrap) state_d = S_DATA;
      end
      S_DATA: begin
        if (timer_wrap) begin
          sreg_d = sreg_q << 1;
          if (idx_q == '0) begin
`ifdef TRI_BUS_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q - IW'(1);
          end
        end
      end
`ifdef TRI_BUS_PARITY_EN
      S_PARITY: begin
        if (timer_wrap) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (timer_wrap) begin
          if (TURN_BITS == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_TURN;
            idx_d   = IW'(TURN_BITS - 1);
          end
        end
      end
      S_TURN: begin
        if (timer_wrap) begin
          if (idx_q == '0) state_d = S_IDLE;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state. This way the registered outputs track the state registers exactly.
  always_comb begin
    drv_in_d   = 1'b0;
    drv_en_d   = 1'b0;
    tx_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_START: begin
        drv_en_d = 1'b1;
        drv_in_d = 1'b0;
      end
      S_DATA: begin
        drv_en_d = 1'b1;
        drv_in_d = sreg_d[DATA_W-1];
      end
`ifdef TRI_BUS_PARITY_EN
      S_PARITY: begin
        drv_en_d = 1'b1;
        drv_in_d = parity_d;
      end
`endif
      S_STOP: begin
        drv_en_d = 1'b1;
        drv_in_d = 1'b1;
      end
      default: begin
        drv_en_d = 1'b0;
        drv_in_d = 1'b0;
      end
    endcase
  end

  // State and output registers. The synchronous reset overrides everything, including a frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      sreg_q     <= '0;
      drv_in_q   <= 1'b0;
      drv_en_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      busy_q     <= 1'b0;
`ifdef TRI_BUS_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      sreg_q     <= sreg_d;
      drv_in_q   <= drv_in_d;
      drv_en_q   <= drv_en_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
`ifdef TRI_BUS_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign drv_in   = drv_in_q;
  assign drv_en   = drv_en_q;
  assign tx_ready = tx_ready_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_tri_state_bus_tx_ctrl.sv
// Testbench for tri_state_bus_tx_ctrl (default parameters).
// Expected per-cycle line states {busy, tx_ready, drv_en, drv_in} are pushed
// to a queue when a word is offered. They are popped and compared on each falling edge.
module tb_tri_state_bus_tx_ctrl;

  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int TURN = 2;
`ifdef TRI_BUS_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          drv_in;
  logic          drv_en;
  logic          busy;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  tri_state_bus_tx_ctrl #(
    .DATA_W   (DW),
    .BIT_DIV  (DIV),
    .TURN_BITS(TURN)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .drv_in  (drv_in),
    .drv_en  (drv_en),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // Expected cycles for one frame accepted at the next rising edge.
  // The list ends with the IDLE cycle in which tx_ready comes back.
  function automatic void push_frame(input logic [DW-1:0] w);
    int ones;
    ones = 0;
    for (int i = 0; i < DIV; i++) exp_q.push_back(4'b1010);
    for (int b = DW - 1; b >= 0; b--) begin
      if (w[b]) ones++;
      for (int i = 0; i < DIV; i++) exp_q.push_back({3'b101, w[b]});
    end
    if (P == 1) begin
      for (int i = 0; i < DIV; i++) exp_q.push_back({3'b101, ((ones % 2) == 1) ? 1'b1 : 1'b0});
    end
    for (int i = 0; i < DIV; i++) exp_q.push_back(4'b1011);
    for (int i = 0; i < TURN * DIV; i++) exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0100);
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed {busy,rdy,en,in}=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Pop n expected cycles, or all of them when n<0. On the first cycle, drop tx_valid unless it is held.
  task automatic run_q(input string tag, input int n, input bit hold, input bit scramble);
    int k;
    logic [3:0] e;
    k = 0;
    while (exp_q.size() > 0 && (n < 0 || k < n)) begin
      @(negedge clk);
      if (k == 0 && !hold) tx_valid = 1'b0;
      if (scramble) tx_data = DW'($urandom);
      e = exp_q.pop_front();
      check($sformatf("%s[c%0d]", tag, k + 1), {busy, tx_ready, drv_en, drv_in}, e);
      $display("%s cycle %0d: busy=%b rdy=%b en=%b in=%b exp=%b", tag, k + 1, busy, tx_ready, drv_en, drv_in, e);
      k++;
    end
    tx_valid = 1'b0;
  endtask

  task automatic send(input string tag, input logic [DW-1:0] w, input bit scramble);
    tx_data  = w;
    tx_valid = 1'b1;
    push_frame(w);
    run_q(tag, -1, 1'b0, scramble);
  endtask

  initial begin
    // 1. Reset with tx_valid high: no accept, reset values shown.
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    @(negedge clk);
    check("reset_c1", {busy, tx_ready, drv_en, drv_in}, 4'b0100);
    @(negedge clk);
    check("reset_c2", {busy, tx_ready, drv_en, drv_in}, 4'b0100);
    rst      = 1'b0;
    tx_valid = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {busy, tx_ready, drv_en, drv_in}, 4'b0100);
    $display("reset: busy=%b rdy=%b en=%b in=%b", busy, tx_ready, drv_en, drv_in);

    // 2. Single frame 8'hA5.
    send("a5", 8'hA5, 1'b0);

    // 3. Back-to-back with tx_valid held: 8'h3C then 8'h81, with one IDLE cycle between.
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    push_frame(8'h3C);
    push_frame(8'h81);
    @(negedge clk);
    tx_data = 8'h81;
    check("b2b_c1", {busy, tx_ready, drv_en, drv_in}, exp_q.pop_front());
    run_q("b2b", -1, 1'b1, 1'b0);

    // 4. Reset during DATA bit 3 of 8'hF0, then a clean 8'hFF frame.
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    push_frame(8'hF0);
    run_q("f0", 21, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midframe_reset", {busy, tx_ready, drv_en, drv_in}, 4'b0100);
    $display("midframe reset: busy=%b rdy=%b en=%b in=%b", busy, tx_ready, drv_en, drv_in);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", {busy, tx_ready, drv_en, drv_in}, 4'b0100);
    send("ff", 8'hFF, 1'b0);

    // 6. tx_data scrambled every cycle after accept of 8'h5A.
    send("5a_scr", 8'h5A, 1'b1);

`ifdef TRI_BUS_PARITY_EN
    // 5. Parity frames.
    send("par07", 8'h07, 1'b0);
    send("par03", 8'h03, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
